// File: rtl/mb_nq_if.sv
// mb_nq_if
//   Bundles the mb_nq data path into one interface: the per-queue write
//   port from QS, the read requests from TS, the drop-counter clear, and
//   all status and pop outputs seen by GC/LCM/TS.
//   master : the side that drives the write/read/clear inputs (QS/TS/bench)
//   slave  : the metadata buffer itself
// Signals
//   in_mb_md            QUEUE_NUM*MD_WIDTH  write data, queue i at [i*MD_WIDTH +: MD_WIDTH]
//   in_mb_md_wr         QUEUE_NUM           write strobe per queue
//   in_mb_q_rden        QUEUE_NUM           read request per queue
//   in_mb_cnt_clr       1                   clear all drop counters
//   out_mb_head         QUEUE_NUM*MD_WIDTH  head word per queue, 0 when empty
//   out_mb_fifo_empty   QUEUE_NUM           queue empty flags
//   out_mb_fifo_full    QUEUE_NUM           queue full flags
//   out_mb_q_used_cnt   QUEUE_NUM*CNT_W     occupancy per queue
//   out_mb_drop_cnt     QUEUE_NUM*8         saturating dropped-write count per queue
//   out_mb_md           MD_WIDTH            popped word, registered
//   out_mb_md_wr        1                   valid for out_mb_md
interface mb_nq_if #(
   parameter int QUEUE_NUM  = 4,
   parameter int MD_WIDTH   = 16,
   parameter int DEPTH_LOG2 = 4,
   parameter int CNT_W      = DEPTH_LOG2 + 1
);
   logic [QUEUE_NUM*MD_WIDTH-1:0] in_mb_md;
   logic [QUEUE_NUM-1:0]          in_mb_md_wr;
   logic [QUEUE_NUM-1:0]          in_mb_q_rden;
   logic                          in_mb_cnt_clr;

   logic [QUEUE_NUM*MD_WIDTH-1:0] out_mb_head;
   logic [QUEUE_NUM-1:0]          out_mb_fifo_empty;
   logic [QUEUE_NUM-1:0]          out_mb_fifo_full;
   logic [QUEUE_NUM*CNT_W-1:0]    out_mb_q_used_cnt;
   logic [QUEUE_NUM*8-1:0]        out_mb_drop_cnt;
   logic [MD_WIDTH-1:0]           out_mb_md;
   logic                          out_mb_md_wr;

   modport master (
      output in_mb_md, in_mb_md_wr, in_mb_q_rden, in_mb_cnt_clr,
      input  out_mb_head, out_mb_fifo_empty, out_mb_fifo_full,
             out_mb_q_used_cnt, out_mb_drop_cnt, out_mb_md, out_mb_md_wr
   );

   modport slave (
      input  in_mb_md, in_mb_md_wr, in_mb_q_rden, in_mb_cnt_clr,
      output out_mb_head, out_mb_fifo_empty, out_mb_fifo_full,
             out_mb_q_used_cnt, out_mb_drop_cnt, out_mb_md, out_mb_md_wr
   );
endinterface

// File: rtl/mb_nq.sv
// mb_nq
//   Metadata buffer: QUEUE_NUM independent first-word-fall-through queues
//   holding per-class packet metadata written by QS. Each queue exposes its
//   head word, empty/full flags, occupancy and a saturating dropped-write
//   counter. TS read requests pop at most one queue per cycle (lowest
//   non-empty requesting index wins); the popped word is presented on
//   out_mb_md with out_mb_md_wr one cycle later.
// Ports
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    mb_nq_if slave modport (write/read/clear in, status/pop out)
module mb_nq #(
   parameter int QUEUE_NUM  = 4,
   parameter int MD_WIDTH   = 16,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic    clk,
   input  logic    rst_n,
   mb_nq_if.slave  bus
);

   localparam int CNT_W = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;

   // Per-queue status gathered from the generate blocks
   logic [QUEUE_NUM-1:0]          empty_vec;
   logic [QUEUE_NUM-1:0]          req;
   logic [QUEUE_NUM-1:0]          pop;
   logic [QUEUE_NUM*MD_WIDTH-1:0] head_vec;

   // Popped-word output stage
   logic [MD_WIDTH-1:0] md_reg;
   logic [MD_WIDTH-1:0] md_next;
   logic                md_wr_reg;
   logic                md_wr_next;

   // ------------------------------------------------------------------
   // Read arbitration: empty queues are masked out before the priority
   // pick so an empty low-index request never blocks a higher one.
   // req & -req isolates the lowest set bit.
   // ------------------------------------------------------------------
   assign req = bus.in_mb_q_rden & ~empty_vec;
   assign pop = req & ((~req) + QUEUE_NUM'(1));

   always_comb begin
      md_next    = '0;
      md_wr_next = |pop;
      for (int i = 0; i < QUEUE_NUM; i++) begin
         if (pop[i]) begin
            md_next = md_next | head_vec[i*MD_WIDTH +: MD_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         md_reg    <= '0;
         md_wr_reg <= 1'b0;
      end else begin
         md_reg    <= md_next;
         md_wr_reg <= md_wr_next;
      end
   end

   assign bus.out_mb_md    = md_reg;
   assign bus.out_mb_md_wr = md_wr_reg;

   // ------------------------------------------------------------------
   // Per-queue storage and bookkeeping
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < QUEUE_NUM; gi++) begin : g_q
         logic [MD_WIDTH-1:0]   mem_reg [DEPTH];
         logic [DEPTH_LOG2-1:0] wptr_reg;
         logic [DEPTH_LOG2-1:0] wptr_next;
         logic [DEPTH_LOG2-1:0] rptr_reg;
         logic [DEPTH_LOG2-1:0] rptr_next;
         logic [CNT_W-1:0]      cnt_reg;
         logic [CNT_W-1:0]      cnt_next;
         logic                  empty_reg;
         logic                  full_reg;
         logic [MD_WIDTH-1:0]   head_reg;
         logic [7:0]            drop_reg;
         logic [7:0]            drop_next;
         logic [MD_WIDTH-1:0]   wdata;
         logic                  wr_acc;
         logic                  drop;

         assign wdata = bus.in_mb_md[gi*MD_WIDTH +: MD_WIDTH];

         // A full queue still accepts a write when it is popped in the
         // same cycle, because the pop frees the slot the write lands in.
         assign wr_acc = bus.in_mb_md_wr[gi] & (~full_reg | pop[gi]);
         assign drop   = bus.in_mb_md_wr[gi] & full_reg & ~pop[gi];

         always_comb begin
            wptr_next = wptr_reg;
            rptr_next = rptr_reg;
            cnt_next  = cnt_reg + CNT_W'(wr_acc) - CNT_W'(pop[gi]);
            drop_next = drop_reg;
            if (wr_acc) begin
               wptr_next = wptr_reg + DEPTH_LOG2'(1);
            end
            if (pop[gi]) begin
               rptr_next = rptr_reg + DEPTH_LOG2'(1);
            end
            // Clear has priority over a simultaneous drop
            if (bus.in_mb_cnt_clr) begin
               drop_next = '0;
            end else if (drop && (drop_reg != 8'hFF)) begin
               drop_next = drop_reg + 8'd1;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               wptr_reg  <= '0;
               rptr_reg  <= '0;
               cnt_reg   <= '0;
               empty_reg <= 1'b1;
               full_reg  <= 1'b0;
               drop_reg  <= '0;
            end else begin
               wptr_reg  <= wptr_next;
               rptr_reg  <= rptr_next;
               cnt_reg   <= cnt_next;
               empty_reg <= (cnt_next == '0);
               full_reg  <= (cnt_next == CNT_W'(DEPTH));
               drop_reg  <= drop_next;
            end
         end

         // Storage has no reset: contents are meaningless until written,
         // and the pointers/count already discard anything left over.
         always_ff @(posedge clk) begin
            if (wr_acc) begin
               mem_reg[wptr_reg] <= wdata;
            end
         end

         // Registered head: fetch the word that will sit at the read
         // pointer after this edge. The only case where that word is being
         // written on this same edge is a write into a queue that would
         // otherwise be empty, so forward the write data there.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               head_reg <= '0;
            end else if (cnt_next == '0) begin
               head_reg <= '0;
            end else if (wr_acc && (wptr_reg == rptr_next)) begin
               head_reg <= wdata;
            end else begin
               head_reg <= mem_reg[rptr_next];
            end
         end

         assign empty_vec[gi]                           = empty_reg;
         assign head_vec[gi*MD_WIDTH +: MD_WIDTH]       = empty_reg ? '0 : head_reg;
         assign bus.out_mb_head[gi*MD_WIDTH +: MD_WIDTH] = empty_reg ? '0 : head_reg;
         assign bus.out_mb_fifo_empty[gi]               = empty_reg;
         assign bus.out_mb_fifo_full[gi]                = full_reg;
         assign bus.out_mb_q_used_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
         assign bus.out_mb_drop_cnt[gi*8 +: 8]           = drop_reg;
      end
   endgenerate

endmodule

// File: tb/tb_mb_nq.sv
// tb_mb_nq
//   Self-checking bench for mb_nq (4 queues, 16-bit words, depth 16).
//   A behavioural model of the queues predicts every pop; predicted words
//   go into a scoreboard queue and a monitor compares them with out_mb_md
//   one cycle later. Scenario tasks check flags, heads, counts and drop
//   counters inline against the model or fixed values.
module tb_mb_nq;

   logic clk;
   logic rst_n;

   int checks;
   int failures;

   mb_nq_if #(.QUEUE_NUM(4), .MD_WIDTH(16), .DEPTH_LOG2(4)) bus ();

   mb_nq #(.QUEUE_NUM(4), .MD_WIDTH(16), .DEPTH_LOG2(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state
   logic [15:0] model_q [4][$];
   logic [7:0]  model_drop [4];
   logic [15:0] exp_q [$];

   function automatic logic [63:0] put(input int q, input logic [15:0] v);
      logic [63:0] d;
      d = '0;
      d[q*16 +: 16] = v;
      return d;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         model_q[i].delete();
         model_drop[i] = 8'd0;
      end
      exp_q.delete();
   endtask

   // Drive one cycle of stimulus at the falling edge, update the model,
   // and return 1 time unit after the following rising edge.
   task automatic drive(input logic [3:0] wr, input logic [63:0] wdata,
                        input logic [3:0] rden, input logic clr);
      logic [3:0] p;
      @(negedge clk);
      bus.in_mb_md_wr   = wr;
      bus.in_mb_md      = wdata;
      bus.in_mb_q_rden  = rden;
      bus.in_mb_cnt_clr = clr;
      p = '0;
      for (int i = 0; i < 4; i++) begin
         if (p == 4'd0 && rden[i] && model_q[i].size() != 0) p[i] = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
         if (p[i]) exp_q.push_back(model_q[i].pop_front());
         if (wr[i]) begin
            if (model_q[i].size() < 16) model_q[i].push_back(wdata[i*16 +: 16]);
            else if (!clr && model_drop[i] != 8'd255) model_drop[i] = model_drop[i] + 8'd1;
         end
         if (clr) model_drop[i] = 8'd0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(4'b0, 64'd0, 4'b0, 1'b0);
   endtask

   // Scoreboard monitor: every predicted pop must appear exactly one cycle later
   always @(posedge clk) begin
      logic [15:0] e;
      #2;
      if (rst_n) begin
         if (bus.out_mb_md_wr === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected_pop got md=%h md_wr=1 required md_wr=0", bus.out_mb_md);
            end else begin
               e = exp_q.pop_front();
               if (bus.out_mb_md !== e) begin
                  failures++;
                  $display("FAIL sb_data got %h required %h", bus.out_mb_md, e);
               end
            end
         end else if (exp_q.size() != 0) begin
            checks++;
            failures++;
            e = exp_q.pop_front();
            $display("FAIL sb_missing_pop got md_wr=%b required md_wr=1 md=%h", bus.out_mb_md_wr, e);
         end
      end
   end

   task automatic test_reset();
      checks++;
      if (bus.out_mb_fifo_empty !== 4'hF || bus.out_mb_fifo_full !== 4'h0) begin
         failures++;
         $display("FAIL reset_flags got empty=%b full=%b required empty=1111 full=0000",
                  bus.out_mb_fifo_empty, bus.out_mb_fifo_full);
      end
      checks++;
      if (bus.out_mb_md !== 16'h0 || bus.out_mb_md_wr !== 1'b0 || bus.out_mb_head !== 64'h0) begin
         failures++;
         $display("FAIL reset_out got md=%h md_wr=%b head=%h required all 0",
                  bus.out_mb_md, bus.out_mb_md_wr, bus.out_mb_head);
      end
      checks++;
      if (bus.out_mb_q_used_cnt !== 20'h0 || bus.out_mb_drop_cnt !== 32'h0) begin
         failures++;
         $display("FAIL reset_cnt got used=%h drop=%h required 0", bus.out_mb_q_used_cnt, bus.out_mb_drop_cnt);
      end
   endtask

   task automatic test_single_write();
      drive(4'b0100, put(2, 16'h1234), 4'b0, 1'b0);
      checks++;
      if (bus.out_mb_fifo_empty !== 4'b1011) begin
         failures++;
         $display("FAIL single_empty got %b required 1011", bus.out_mb_fifo_empty);
      end
      checks++;
      if (bus.out_mb_q_used_cnt[10 +: 5] !== 5'd1 || bus.out_mb_head[32 +: 16] !== 16'h1234) begin
         failures++;
         $display("FAIL single_head got used=%0d head=%h required used=1 head=1234",
                  bus.out_mb_q_used_cnt[10 +: 5], bus.out_mb_head[32 +: 16]);
      end
      drive(4'b0, 64'd0, 4'b0100, 1'b0);
      checks++;
      if (bus.out_mb_md !== 16'h1234 || bus.out_mb_md_wr !== 1'b1) begin
         failures++;
         $display("FAIL single_pop got md=%h md_wr=%b required md=1234 md_wr=1", bus.out_mb_md, bus.out_mb_md_wr);
      end
      idle();
   endtask

   task automatic test_fill_drop();
      for (int k = 0; k < 16; k++) drive(4'b0001, put(0, 16'(k)), 4'b0, 1'b0);
      checks++;
      if (bus.out_mb_fifo_full[0] !== 1'b1 || bus.out_mb_q_used_cnt[0 +: 5] !== 5'd16) begin
         failures++;
         $display("FAIL fill_full got full=%b used=%0d required full=1 used=16",
                  bus.out_mb_fifo_full[0], bus.out_mb_q_used_cnt[0 +: 5]);
      end
      drive(4'b0001, put(0, 16'h00EE), 4'b0, 1'b0);
      checks++;
      if (bus.out_mb_drop_cnt[0 +: 8] !== 8'd1 || bus.out_mb_head[0 +: 16] !== 16'h0000 ||
          bus.out_mb_q_used_cnt[0 +: 5] !== 5'd16) begin
         failures++;
         $display("FAIL fill_drop got drop=%0d head=%h used=%0d required drop=1 head=0000 used=16",
                  bus.out_mb_drop_cnt[0 +: 8], bus.out_mb_head[0 +: 16], bus.out_mb_q_used_cnt[0 +: 5]);
      end
      for (int k = 0; k < 16; k++) begin
         drive(4'b0, 64'd0, 4'b0001, 1'b0);
         checks++;
         if (bus.out_mb_md !== 16'(k)) begin
            failures++;
            $display("FAIL fill_order got %h required %h", bus.out_mb_md, 16'(k));
         end
      end
      idle();
      checks++;
      if (bus.out_mb_fifo_empty[0] !== 1'b1) begin
         failures++;
         $display("FAIL fill_empty got %b required 1", bus.out_mb_fifo_empty[0]);
      end
   endtask

   task automatic test_arbitration();
      drive(4'b1010, put(1, 16'h00A1) | put(3, 16'h00C1), 4'b0, 1'b0);
      drive(4'b0010, put(1, 16'h00A2), 4'b0, 1'b0);
      drive(4'b0, 64'd0, 4'b1010, 1'b0);
      checks++;
      if (bus.out_mb_md !== 16'h00A1 || bus.out_mb_q_used_cnt[15 +: 5] !== 5'd1 ||
          bus.out_mb_q_used_cnt[5 +: 5] !== 5'd1) begin
         failures++;
         $display("FAIL arb_low got md=%h used1=%0d used3=%0d required md=00a1 used1=1 used3=1",
                  bus.out_mb_md, bus.out_mb_q_used_cnt[5 +: 5], bus.out_mb_q_used_cnt[15 +: 5]);
      end
      drive(4'b0, 64'd0, 4'b0011, 1'b0);
      checks++;
      if (bus.out_mb_md !== 16'h00A2 || bus.out_mb_md_wr !== 1'b1 || bus.out_mb_fifo_empty !== 4'b0111) begin
         failures++;
         $display("FAIL arb_skip_empty got md=%h md_wr=%b empty=%b required md=00a2 md_wr=1 empty=0111",
                  bus.out_mb_md, bus.out_mb_md_wr, bus.out_mb_fifo_empty);
      end
      drive(4'b0, 64'd0, 4'b1000, 1'b0);
      checks++;
      if (bus.out_mb_md !== 16'h00C1) begin
         failures++;
         $display("FAIL arb_q3 got %h required 00c1", bus.out_mb_md);
      end
      idle();
   endtask

   task automatic test_simultaneous();
      for (int k = 0; k < 16; k++) drive(4'b0001, put(0, 16'(16'h0100 + k)), 4'b0, 1'b0);
      drive(4'b0001, put(0, 16'h01FF), 4'b0001, 1'b0);
      checks++;
      if (bus.out_mb_drop_cnt[0 +: 8] !== model_drop[0] || bus.out_mb_q_used_cnt[0 +: 5] !== 5'd16 ||
          bus.out_mb_head[0 +: 16] !== 16'h0101 || bus.out_mb_md !== 16'h0100) begin
         failures++;
         $display("FAIL sim_full_wr_pop got drop=%0d used=%0d head=%h md=%h required drop=%0d used=16 head=0101 md=0100",
                  bus.out_mb_drop_cnt[0 +: 8], bus.out_mb_q_used_cnt[0 +: 5], bus.out_mb_head[0 +: 16],
                  bus.out_mb_md, model_drop[0]);
      end
      drive(4'b1000, put(3, 16'h3333), 4'b1000, 1'b0);
      checks++;
      if (bus.out_mb_md_wr !== 1'b0 || bus.out_mb_q_used_cnt[15 +: 5] !== 5'd1 ||
          bus.out_mb_head[48 +: 16] !== 16'h3333) begin
         failures++;
         $display("FAIL sim_empty_wr_rd got md_wr=%b used=%0d head=%h required md_wr=0 used=1 head=3333",
                  bus.out_mb_md_wr, bus.out_mb_q_used_cnt[15 +: 5], bus.out_mb_head[48 +: 16]);
      end
      for (int k = 0; k < 17; k++) drive(4'b0, 64'd0, 4'b1001, 1'b0);
      idle();
      checks++;
      if (bus.out_mb_fifo_empty !== 4'hF) begin
         failures++;
         $display("FAIL sim_drain got empty=%b required 1111", bus.out_mb_fifo_empty);
      end
   endtask

   task automatic test_wrap_sat();
      drive(4'b0100, put(2, 16'h2000), 4'b0, 1'b0);
      for (int i = 1; i < 40; i++) begin
         drive(4'b0100, put(2, 16'(16'h2000 + i)), 4'b0100, 1'b0);
         checks++;
         if (bus.out_mb_md !== 16'(16'h2000 + i - 1) || bus.out_mb_head[32 +: 16] !== 16'(16'h2000 + i)) begin
            failures++;
            $display("FAIL wrap_order got md=%h head=%h required md=%h head=%h", bus.out_mb_md,
                     bus.out_mb_head[32 +: 16], 16'(16'h2000 + i - 1), 16'(16'h2000 + i));
         end
      end
      drive(4'b0, 64'd0, 4'b0100, 1'b0);
      idle();
      for (int k = 0; k < 316; k++) drive(4'b0010, put(1, 16'(k)), 4'b0, 1'b0);
      checks++;
      if (bus.out_mb_drop_cnt[8 +: 8] !== 8'd255 || model_drop[1] !== 8'd255) begin
         failures++;
         $display("FAIL sat_255 got %0d required 255", bus.out_mb_drop_cnt[8 +: 8]);
      end
      // Clear coincides with another overflowing write: clear wins
      drive(4'b0010, put(1, 16'hDEAD), 4'b0, 1'b1);
      checks++;
      if (bus.out_mb_drop_cnt !== 32'h0) begin
         failures++;
         $display("FAIL sat_clear got %h required 0", bus.out_mb_drop_cnt);
      end
      for (int k = 0; k < 16; k++) drive(4'b0, 64'd0, 4'b0010, 1'b0);
      idle();
   endtask

   task automatic test_async_reset();
      drive(4'b0011, put(0, 16'h0BAD) | put(1, 16'h0BEE), 4'b0, 1'b0);
      drive(4'b0010, put(1, 16'h0BEF), 4'b0001, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (bus.out_mb_md_wr !== 1'b0 || bus.out_mb_md !== 16'h0 || bus.out_mb_fifo_empty !== 4'hF ||
          bus.out_mb_q_used_cnt !== 20'h0 || bus.out_mb_head !== 64'h0) begin
         failures++;
         $display("FAIL async_reset got md_wr=%b md=%h empty=%b used=%h head=%h required 0/0/1111/0/0",
                  bus.out_mb_md_wr, bus.out_mb_md, bus.out_mb_fifo_empty, bus.out_mb_q_used_cnt, bus.out_mb_head);
      end
      bus.in_mb_md_wr   = '0;
      bus.in_mb_q_rden  = '0;
      bus.in_mb_cnt_clr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b0001, put(0, 16'h5A5A), 4'b0, 1'b0);
      checks++;
      if (bus.out_mb_head[0 +: 16] !== 16'h5A5A || bus.out_mb_q_used_cnt[0 +: 5] !== 5'd1 ||
          bus.out_mb_head[16 +: 16] !== 16'h0 || bus.out_mb_fifo_empty !== 4'b1110) begin
         failures++;
         $display("FAIL post_reset got head0=%h used0=%0d head1=%h empty=%b required 5a5a/1/0000/1110",
                  bus.out_mb_head[0 +: 16], bus.out_mb_q_used_cnt[0 +: 5], bus.out_mb_head[16 +: 16],
                  bus.out_mb_fifo_empty);
      end
      drive(4'b0, 64'd0, 4'b0011, 1'b0);
      checks++;
      if (bus.out_mb_md !== 16'h5A5A || bus.out_mb_md_wr !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_pop got md=%h md_wr=%b required 5a5a/1", bus.out_mb_md, bus.out_mb_md_wr);
      end
      idle();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.in_mb_md      = '0;
      bus.in_mb_md_wr   = '0;
      bus.in_mb_q_rden  = '0;
      bus.in_mb_cnt_clr = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      test_reset();
      test_single_write();
      test_fill_drop();
      test_arbitration();
      test_simultaneous();
      test_wrap_sat();
      test_async_reset();
      repeat (2) @(posedge clk);
      #3;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
